pipe_reg_elastic: RTL and testbench



---
 rtl/pipe_reg_elastic.sv | 129 ++++++++++++
 tb/tb_pipe_reg_elastic.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_elastic.sv
// rtl/pipe_reg_elastic.sv - elastic DEPTH-stage pipeline register with optional skid slot
// Empty stages always load, so bubbles collapse; clear flushes valid state only.
module pipe_reg_elastic #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  parameter  int SKID  = 1,
  localparam int CW    = $clog2(DEPTH + 2)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;

  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] stg_v;
  logic [WIDTH-1:0] stg_d [DEPTH];
  logic             src_v;
  logic [WIDTH-1:0] src_d;
  logic             in_hs;
  logic             out_hs;

  // rdy[i]: some stage at or after i is empty, or the sink takes the last word
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rdy[i] = out_ready;
      for (int j = i; j < DEPTH; j++) begin
        if (!v_q[j]) rdy[i] = 1'b1;
      end
    end
  end

  assign out_valid = v_q[DEPTH-1] & ~clear;
  assign out_data  = d_q[DEPTH-1];
  assign count     = count_q;
  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;

  if (SKID != 0) begin : g_skid
    logic             sv_q, sv_d;
    logic [WIDTH-1:0] sd_q, sd_d;

    // Registered ready: the skid slot absorbs the word taken while S0 was blocked
    assign in_ready = reset_n & ~clear & ~sv_q;
    assign src_v    = sv_q | in_hs;
    assign src_d    = sv_q ? sd_q : in_data;

    always_comb begin
      sv_d = sv_q;
      sd_d = sd_q;
      if (clear || rdy[0]) begin
        sv_d = 1'b0;
      end else if (in_hs) begin
        sv_d = 1'b1;
        sd_d = in_data;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sv_q <= 1'b0;
        sd_q <= '0;
      end else begin
        sv_q <= sv_d;
        sd_q <= sd_d;
      end
    end
  end else begin : g_direct
    assign in_ready = reset_n & ~clear & rdy[0];
    assign src_v    = in_hs;
    assign src_d    = in_data;
  end

  always_comb begin
    stg_v[0] = src_v;
    stg_d[0] = src_d;
    for (int i = 1; i < DEPTH; i++) begin
      stg_v[i] = v_q[i-1];
      stg_d[i] = d_q[i-1];
    end
  end

  always_comb begin
    v_d = v_q;
    for (int i = 0; i < DEPTH; i++) begin
      d_d[i] = d_q[i];
      if (rdy[i]) begin
        v_d[i] = stg_v[i];
        if (stg_v[i]) d_d[i] = stg_d[i];
      end
    end
    if (clear) v_d = '0;
  end

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (in_hs && !out_hs) begin
      count_d = count_q + CW'(1);
    end else if (out_hs && !in_hs) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q     <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
    end else begin
      v_q     <= v_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) d_q[i] <= d_d[i];
    end
  end

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// tb/tb_pipe_reg_elastic.sv - bench for pipe_reg_elastic across DEPTH/SKID variants
// All variants share stimulus; a word/position queue model predicts each one.
module tb_pipe_reg_elastic;

  localparam int NI = 8;

  function automatic int dep_of(input int g);
    case (g)
      0, 1:    return 1;
      2, 3:    return 2;
      4:       return 3;
      5:       return 4;
      default: return 5;
    endcase
  endfunction

  function automatic int skid_of(input int g);
    return (g == 0 || g == 2 || g == 6) ? 0 : 1;
  endfunction

  logic clk = 1'b0;
  logic reset_n;
  logic clear;
  logic in_valid;
  logic [7:0] in_data;
  logic out_ready;

  logic [NI-1:0]      ir;
  logic [NI-1:0]      ov;
  logic [NI-1:0][7:0] od;
  logic [NI-1:0][3:0] cnt;

  int vectors = 0;
  int miscompares = 0;

  // Model: per variant, words in acceptance order with position (-1 = skid/input)
  int         mn [NI];
  int         mp [NI][8];
  logic [7:0] md [NI][8];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int D   = dep_of(g);
    localparam int S   = skid_of(g);
    localparam int CWL = $clog2(D + 2);
    logic [CWL-1:0] c;
    logic [7:0]     o;
    logic           r;
    logic           v;

    pipe_reg_elastic #(.WIDTH(8), .DEPTH(D), .SKID(S)) u_dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear    (clear),
      .in_valid (in_valid),
      .in_ready (r),
      .in_data  (in_data),
      .out_valid(v),
      .out_ready(out_ready),
      .out_data (o),
      .count    (c)
    );

    assign ir[g]  = r;
    assign ov[g]  = v;
    assign od[g]  = o;
    assign cnt[g] = 4'(c);
  end

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s[dut %0d] t=%0t: got 0x%0h, expected 0x%0h", nm, g, $time, act, exp_v);
    end
  endtask

  task automatic model_cycle();
    for (int g = 0; g < NI; g++) begin
      int  d;
      int  n;
      bit  e_ir;
      bit  e_ov;
      bit  skid_busy;
      d = dep_of(g);
      n = mn[g];
      if (!reset_n) begin
        chk("rst_in_ready", g, 32'(ir[g]), 0);
        chk("rst_out_valid", g, 32'(ov[g]), 0);
        chk("rst_out_data", g, 32'(od[g]), 0);
        chk("rst_count", g, 32'(cnt[g]), 0);
        mn[g] = 0;
      end else begin
        e_ov      = (n > 0) && (mp[g][0] == d - 1) && !clear;
        skid_busy = (n > 0) && (mp[g][n-1] == -1);
        if (skid_of(g) != 0) e_ir = !clear && !skid_busy;
        else                 e_ir = !clear && ((n < d) || out_ready);
        chk("in_ready", g, 32'(ir[g]), 32'(e_ir));
        chk("out_valid", g, 32'(ov[g]), 32'(e_ov));
        chk("count", g, 32'(cnt[g]), n);
        if (e_ov) chk("out_data", g, 32'(od[g]), 32'(md[g][0]));
        if (clear) begin
          mn[g] = 0;
        end else begin
          if (in_valid && e_ir) begin
            md[g][n] = in_data;
            mp[g][n] = -1;
            n++;
          end
          // A word advances if any slot ahead of it is free or the sink is taking
          for (int k = 0; k < n; k++) begin
            if ((k < d - 1 - mp[g][k]) || out_ready) mp[g][k]++;
          end
          if (n > 0 && mp[g][0] == d) begin
            for (int k = 1; k < n; k++) begin
              md[g][k-1] = md[g][k];
              mp[g][k-1] = mp[g][k];
            end
            n--;
          end
          mn[g] = n;
        end
      end
    end
  endtask

  task automatic drive(input bit iv, input logic [7:0] dt, input bit ordy, input bit clr);
    in_valid  = iv;
    in_data   = dt;
    out_ready = ordy;
    clear     = clr;
  endtask

  task automatic smp();
    @(negedge clk);
    model_cycle();
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    smp();
    nxt();
  endtask

  task automatic drain();
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (8) cyc();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    for (int g = 0; g < NI; g++) mn[g] = 0;
    reset_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) cyc();
    smp();
    chk("rst_ready_all", 0, 32'(ir), 0);
    chk("rst_valid_all", 0, 32'(ov), 0);
    nxt();
    reset_n = 1'b1;
    smp();
    chk("ready_after_rst", 0, 32'(ir), 32'hFF);
    nxt();

    // Stream on DEPTH=2 SKID=1: latency 2, 16 words in order, count steady at 2
    for (int t = 0; t < 20; t++) begin
      if (t < 16) drive(1'b1, 8'(t + 1), 1'b1, 1'b0);
      else        drive(1'b0, 8'h00, 1'b1, 1'b0);
      smp();
      chk("stream_valid", 3, 32'(ov[3]), 32'(t >= 2 && t <= 17));
      if (t >= 2 && t <= 17) chk("stream_data", 3, 32'(od[3]), t - 1);
      if (t >= 2 && t <= 16) chk("stream_count", 3, 32'(cnt[3]), 2);
      nxt();
    end

    // Backpressure on DEPTH=3 SKID=1: four words held, ready returns after first output
    drain();
    for (int t = 0; t < 13; t++) begin
      if (t < 8) drive(1'b1, 8'(8'hA0 + t), 1'b0, 1'b0);
      else       drive(1'b0, 8'h00, 1'b1, 1'b0);
      smp();
      if (t == 4 || t == 8) begin
        chk("bp_ready_full", 4, 32'(ir[4]), 0);
        chk("bp_count_full", 4, 32'(cnt[4]), 4);
      end
      if (t == 9) chk("bp_ready_back", 4, 32'(ir[4]), 1);
      if (t >= 8 && t <= 11) begin
        chk("bp_out_valid", 4, 32'(ov[4]), 1);
        chk("bp_out_data", 4, 32'(od[4]), 32'(8'hA0 + t - 8));
      end
      if (t == 12) chk("bp_out_idle", 4, 32'(ov[4]), 0);
      nxt();
    end

    // Bubble collapse on DEPTH=4: second word closes up behind the stalled first
    drain();
    for (int t = 0; t < 13; t++) begin
      drive(t == 0 || t == 7, (t == 0) ? 8'h11 : 8'h22, t >= 10, 1'b0);
      smp();
      if (t == 8 || t == 9) chk("bubble_count", 5, 32'(cnt[5]), 2);
      if (t == 10) begin
        chk("bubble_v0", 5, 32'(ov[5]), 1);
        chk("bubble_d0", 5, 32'(od[5]), 32'h11);
      end
      if (t == 11) begin
        chk("bubble_v1", 5, 32'(ov[5]), 1);
        chk("bubble_d1", 5, 32'(od[5]), 32'h22);
      end
      if (t == 12) chk("bubble_idle", 5, 32'(ov[5]), 0);
      nxt();
    end

    // Clear on DEPTH=2 SKID=0 while full, with in_valid and out_ready high
    drain();
    for (int t = 0; t < 8; t++) begin
      case (t)
        0:       drive(1'b1, 8'h55, 1'b0, 1'b0);
        1:       drive(1'b1, 8'h66, 1'b0, 1'b0);
        2:       drive(1'b1, 8'h77, 1'b1, 1'b1);
        default: drive(1'b0, 8'h00, 1'b1, 1'b0);
      endcase
      smp();
      if (t == 2) begin
        chk("clr_ready", 2, 32'(ir[2]), 0);
        chk("clr_valid", 2, 32'(ov[2]), 0);
        chk("clr_count_before", 2, 32'(cnt[2]), 2);
      end
      if (t == 3) chk("clr_count_after", 2, 32'(cnt[2]), 0);
      if (t >= 3) chk("clr_no_output", 2, 32'(ov[2]), 0);
      nxt();
    end

    // Asynchronous reset between edges with three words held in DEPTH=2 SKID=1
    drain();
    for (int t = 0; t < 3; t++) begin
      drive(1'b1, 8'(8'h30 + t), 1'b0, 1'b0);
      cyc();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    smp();
    chk("arst_count_before", 3, 32'(cnt[3]), 3);
    nxt();
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 3, 32'(ov[3]), 0);
    chk("arst_data", 3, 32'(od[3]), 0);
    chk("arst_count", 3, 32'(cnt[3]), 0);
    smp();
    nxt();
    reset_n = 1'b1;
    for (int t = 0; t < 5; t++) begin
      drive(t == 0, 8'h5A, 1'b1, 1'b0);
      smp();
      if (t == 0) chk("arst_ready_after", 3, 32'(ir[3]), 1);
      if (t == 1) chk("arst_latency_early", 3, 32'(ov[3]), 0);
      if (t == 2) begin
        chk("arst_latency_valid", 3, 32'(ov[3]), 1);
        chk("arst_latency_data", 3, 32'(od[3]), 32'h5A);
      end
      nxt();
    end

    // Random valid/ready traffic with occasional clear across all variants
    for (int t = 0; t < 10000; t++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
            $urandom_range(0, 99) == 0);
      cyc();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
